// File: rtl/gc_dram_array_if.sv
// Port bundle for gc_dram_array: write/read/refresh strobes in, read return out.
// The refresh strobe is ref_en because "ref" is a reserved word in SystemVerilog.
interface gc_dram_array_if #(
    parameter int WIDTH = 64,
    parameter int AW    = 7
) ();
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             re;
    logic [AW-1:0]    raddr;
    logic             ref_en;
    logic [AW-1:0]    ref_addr;
    logic [WIDTH-1:0] rd;
    logic             rd_valid;
    logic             rd_err;
    logic [15:0]      fail_cnt;

    modport master (
        output we, waddr, wdata, re, raddr, ref_en, ref_addr,
        input  rd, rd_valid, rd_err, fail_cnt
    );
    modport slave (
        input  we, waddr, wdata, re, raddr, ref_en, ref_addr,
        output rd, rd_valid, rd_err, fail_cnt
    );
endinterface

// File: rtl/gc_dram_array.sv
// Behavioural DRAM row array: each row loses its data RETENTION cycles after the
// last write/refresh unless refreshed. Reads return an error for lost rows.
module gc_dram_array #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 128,
    parameter int RETENTION = 5000,
    parameter int READ_LAT  = 1
) (
    input  logic           clk,
    input  logic           rst,
    gc_dram_array_if.slave bus
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AGW = (RETENTION >= 1) ? $clog2(RETENTION + 1) : 1;

    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $error("gc_dram_array: READ_LAT must be 1 or 2");
    end
    if (RETENTION < 1) begin : g_bad_ret
        $error("gc_dram_array: RETENTION must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("gc_dram_array: DEPTH must be >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] row_live;
    logic             wa_ok;
    logic             ra_ok;

    assign wa_ok = int'(bus.waddr) < DEPTH;
    assign ra_ok = int'(bus.raddr) < DEPTH;

    always_ff @(posedge clk) begin
        if (!rst && bus.we && wa_ok)
            mem[bus.waddr] <= bus.wdata;
    end

    // Per-row retention counter; a write beats a same-row refresh.
    for (genvar r = 0; r < DEPTH; r++) begin : g_row
        localparam logic [AW-1:0] RA = AW'(r);
        logic           live;
        logic [AGW-1:0] age;
        logic           wr_hit;
        logic           rf_hit;

        assign wr_hit = bus.we && (bus.waddr == RA);
        assign rf_hit = bus.ref_en && (bus.ref_addr == RA);

        always_ff @(posedge clk) begin
            if (rst) begin
                live <= 1'b0;
                age  <= '0;
            end else if (wr_hit) begin
                live <= 1'b1;
                age  <= AGW'(RETENTION);
            end else if (live) begin
                if (rf_hit) begin
                    age <= AGW'(RETENTION);
                end else begin
                    age <= age - 1'b1;
                    if (age == AGW'(1))
                        live <= 1'b0;
                end
            end
        end

        assign row_live[r] = live;
    end

    // Read lookup against pre-edge state; a same-row write in the same cycle poisons the read.
    logic             s0_err;
    logic [WIDTH-1:0] s0_dat;

    always_comb begin
        s0_err = 1'b1;
        s0_dat = '0;
        if (ra_ok && row_live[bus.raddr] && !(bus.we && bus.waddr == bus.raddr)) begin
            s0_err = 1'b0;
            s0_dat = mem[bus.raddr];
        end
    end

    logic             f_vld;
    logic             f_err;
    logic [WIDTH-1:0] f_dat;

    if (READ_LAT == 2) begin : g_lat2
        logic             p_vld;
        logic             p_err;
        logic [WIDTH-1:0] p_dat;

        always_ff @(posedge clk) begin
            if (rst) begin
                p_vld <= 1'b0;
                p_err <= 1'b0;
            end else begin
                p_vld <= bus.re;
                p_err <= s0_err;
            end
            p_dat <= s0_dat;
        end

        assign f_vld = p_vld;
        assign f_err = p_err;
        assign f_dat = p_dat;
    end else begin : g_lat1
        assign f_vld = bus.re;
        assign f_err = s0_err;
        assign f_dat = s0_dat;
    end

    // rd holds between reads; fail_cnt moves in the same cycle as the erroring rd_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd       <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
            bus.fail_cnt <= '0;
        end else begin
            bus.rd_valid <= f_vld;
            bus.rd_err   <= f_vld & f_err;
            if (f_vld)
                bus.rd <= f_dat;
            if (f_vld && f_err && bus.fail_cnt != 16'hFFFF)
                bus.fail_cnt <= bus.fail_cnt + 16'd1;
        end
    end
endmodule
